// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller and its BCD digit chain.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when the lowest n BCD digits of v are all 9 (n at most 8).
  function automatic logic all_nines(input logic [31:0] v, input int unsigned n);
    logic r;
    r = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n && v[4*i +: 4] != BCD_MAX) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One mod-10 counter digit; carry marks the enabled 9->0 wrap for the next digit.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] count,
  output logic       carry
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == BCD_MAX) ? 4'd0 : count + 4'd1;
    end
  end

  assign carry = enable && (count == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detection, run/pause/lap FSM, tick prescaler,
// cascaded BCD digits and a lap snapshot that is shown while counting continues.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  output logic                    run,
  output logic                    frozen,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    rollover
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t state, state_nx;
  logic   ss_q, lap_q, clr_q;
  logic   ev_ss, ev_lap, ev_clr;
  logic   counting, tick, zero_chain;
  logic [PW-1:0]             pre;
  logic [NUM_DIGITS-1:0]     carry;
  logic [4*NUM_DIGITS-1:0]   live, snap;

  assign ev_ss  = start_stop && !ss_q;
  assign ev_lap = lap && !lap_q;
  assign ev_clr = clear && !clr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ss_q  <= 1'b0;
      lap_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      state <= state_nx;
      ss_q  <= start_stop;
      lap_q <= lap;
      clr_q <= clear;
    end
  end

  // clear outranks start_stop, which outranks lap; clear only matters in IDLE/PAUSE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (!ev_clr && ev_ss) state_nx = RUN;
      RUN:   if (ev_ss) state_nx = PAUSE; else if (ev_lap) state_nx = LAP;
      LAP:   if (ev_ss) state_nx = PAUSE; else if (ev_lap) state_nx = RUN;
      PAUSE: if (ev_clr) state_nx = IDLE; else if (ev_ss) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    run    = (state == RUN) || (state == LAP);
    frozen = (state == LAP);
    digits = (state == LAP) ? snap : live;
  end

  assign counting   = (state == RUN) || (state == LAP);
  assign tick       = counting && (pre == PRE_LAST);
  assign zero_chain = ev_clr && ((state == IDLE) || (state == PAUSE));

  always_ff @(posedge clk) begin
    if (reset || state == IDLE || zero_chain) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else if (counting) begin
      pre <= pre + PW'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic en;
    if (g == 0) begin : g_first
      assign en = tick;
    end else begin : g_rest
      assign en = carry[g-1];
    end
    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .clear  (zero_chain),
      .enable (en),
      .count  (live[4*g +: 4]),
      .carry  (carry[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap     <= '0;
      rollover <= 1'b0;
    end else begin
      if (state == RUN && state_nx == LAP) snap <= live;
      rollover <= carry[NUM_DIGITS-1] && all_nines(32'(live), NUM_DIGITS);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench: a 4-digit /10 instance for run, lap, pause and clear, and a
// 2-digit /1 instance for the full-scale wrap.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic        start2 = 1'b0, lap2 = 1'b0, clear2 = 1'b0;
  logic        run, frozen, rollover;
  logic [15:0] digits;
  logic        run2, frozen2, rollover2;
  logic [7:0]  digits2;
  int          checks = 0;
  int          errors = 0;

  stopwatch_ctrl #(.TICK_DIV(10), .NUM_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .run(run), .frozen(frozen), .digits(digits), .rollover(rollover)
  );

  stopwatch_ctrl #(.TICK_DIV(1), .NUM_DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .start_stop(start2), .lap(lap2), .clear(clear2),
    .run(run2), .frozen(frozen2), .digits(digits2), .rollover(rollover2)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run got=%b exp=0", run); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen got=%b exp=0", frozen); end
    checks++; if (rollover !== 1'b0) begin errors++; $display("FAIL reset_rollover got=%b exp=0", rollover); end
    checks++; if (digits2 !== 8'h00 || run2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 digits=%h run=%b exp=00/0", digits2, run2); end
    lap = 1'b1; step(1); lap = 1'b0;
    clear = 1'b1; step(1); clear = 1'b0;
    step(1);
    checks++; if (run !== 1'b0 || frozen !== 1'b0) begin errors++; $display("FAIL idle_lap_clear run=%b frozen=%b exp=0/0", run, frozen); end
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL idle_digits got=%h exp=0000", digits); end
  endtask

  task automatic test_run_count;
    start_stop = 1'b1;
    step(1);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL start_run got=%b exp=1", run); end
    step(9);
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL pre_first_tick got=%h exp=0000", digits); end
    step(1);
    checks++; if (digits !== 16'h0001) begin errors++; $display("FAIL first_tick got=%h exp=0001", digits); end
    step(9);
    start_stop = 1'b0;
    step(81);
    checks++; if (digits !== 16'h0010) begin errors++; $display("FAIL run_100 got=%h exp=0010", digits); end
    checks++; if (run !== 1'b1 || frozen !== 1'b0) begin errors++; $display("FAIL held_level run=%b frozen=%b exp=1/0", run, frozen); end
  endtask

  task automatic test_pause_clear;
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL pause_run got=%b exp=0", run); end
    step(20);
    checks++; if (digits !== 16'h0010) begin errors++; $display("FAIL pause_hold got=%h exp=0010", digits); end
    clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL clear_digits got=%h exp=0000", digits); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL clear_run got=%b exp=0", run); end
    step(25);
    checks++; if (run !== 1'b0 || digits !== 16'h0000) begin errors++; $display("FAIL clear_idle run=%b digits=%h exp=0/0000", run, digits); end
  endtask

  task automatic test_lap;
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(52);
    lap = 1'b1; step(1); lap = 1'b0;
    checks++; if (digits !== 16'h0005) begin errors++; $display("FAIL lap_snap got=%h exp=0005", digits); end
    checks++; if (frozen !== 1'b1 || run !== 1'b1) begin errors++; $display("FAIL lap_state frozen=%b run=%b exp=1/1", frozen, run); end
    step(147);
    checks++; if (digits !== 16'h0005) begin errors++; $display("FAIL lap_hold got=%h exp=0005", digits); end
    step(152);
    lap = 1'b1; step(1); lap = 1'b0;
    checks++; if (digits !== 16'h0035) begin errors++; $display("FAIL lap_release got=%h exp=0035", digits); end
    checks++; if (frozen !== 1'b0 || run !== 1'b1) begin errors++; $display("FAIL lap_exit frozen=%b run=%b exp=0/1", frozen, run); end
  endtask

  task automatic test_pause_resume;
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    clear = 1'b1; step(1); clear = 1'b0;
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reclear got=%h exp=0000", digits); end
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(73);
    checks++; if (digits !== 16'h0007) begin errors++; $display("FAIL count_7 got=%h exp=0007", digits); end
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      checks++; if (digits !== 16'h0007) begin errors++; $display("FAIL pause_freeze cyc=%0d got=%h exp=0007", i, digits); end
    end
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(5);
    checks++; if (digits !== 16'h0007) begin errors++; $display("FAIL resume_5 got=%h exp=0007", digits); end
    step(1);
    checks++; if (digits !== 16'h0008) begin errors++; $display("FAIL resume_6 got=%h exp=0008", digits); end
  endtask

  task automatic test_rollover;
    start2 = 1'b1; step(1); start2 = 1'b0;
    step(9);
    checks++; if (digits2 !== 8'h09) begin errors++; $display("FAIL d2_nine got=%h exp=09", digits2); end
    step(1);
    checks++; if (digits2 !== 8'h10) begin errors++; $display("FAIL d2_carry got=%h exp=10", digits2); end
    step(89);
    checks++; if (digits2 !== 8'h99 || rollover2 !== 1'b0) begin errors++; $display("FAIL d2_full digits=%h roll=%b exp=99/0", digits2, rollover2); end
    step(1);
    checks++; if (digits2 !== 8'h00 || rollover2 !== 1'b1) begin errors++; $display("FAIL d2_wrap digits=%h roll=%b exp=00/1", digits2, rollover2); end
    step(1);
    checks++; if (digits2 !== 8'h01 || rollover2 !== 1'b0) begin errors++; $display("FAIL d2_after digits=%h roll=%b exp=01/0", digits2, rollover2); end
  endtask

  task automatic test_reset_mid_run;
    reset = 1'b1; step(1);
    checks++; if (digits !== 16'h0000 || run !== 1'b0 || frozen !== 1'b0 || rollover !== 1'b0) begin
      errors++; $display("FAIL midreset digits=%h run=%b frozen=%b roll=%b exp=0000/0/0/0", digits, run, frozen, rollover);
    end
    checks++; if (digits2 !== 8'h00 || run2 !== 1'b0) begin errors++; $display("FAIL midreset_d2 digits=%h run=%b exp=00/0", digits2, run2); end
    reset = 1'b0; step(3);
    checks++; if (run !== 1'b0 || digits !== 16'h0000) begin errors++; $display("FAIL post_reset run=%b digits=%h exp=0/0000", run, digits); end
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_pause_clear();
    test_lap();
    test_pause_resume();
    test_rollover();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
